// File: rtl/quad_enc_rpm.sv
// x4 quadrature decoder with signed position, direction, illegal-transition flag and windowed RPM.
// Optional glitch filter on the synchronised channels: define QENC_FILTER_EN.
module quad_enc_rpm #(
    parameter int unsigned WINDOW_CYCLES = 50000,
    parameter int unsigned RPM_SCALE     = 30,
    parameter int unsigned CNT_W         = 12,
    parameter int unsigned RPM_W         = 16,
    parameter int unsigned POS_W         = 32,
    parameter int unsigned FILT_LEN      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enc_a,
    input  logic                    enc_b,
    input  logic                    clr_pos,
    output logic signed [POS_W-1:0] pos,
    output logic                    dir,
    output logic signed [RPM_W-1:0] rpm,
    output logic                    rpm_valid,
    output logic                    err
);

    localparam int unsigned WIN_W   = $clog2(WINDOW_CYCLES);
    localparam int unsigned SCALE_W = $clog2(RPM_SCALE + 1);
    localparam int unsigned PROD_W  = CNT_W + SCALE_W;
    localparam int unsigned EXT_W   = ((PROD_W > RPM_W) ? PROD_W : RPM_W) + 1;

    localparam logic [WIN_W-1:0]        WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic signed [CNT_W-1:0] CNT_MAX  = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W-1:0] CNT_MIN  = -CNT_MAX;
    localparam logic signed [EXT_W-1:0] RPM_MAX  = {{(EXT_W-RPM_W+1){1'b0}}, {(RPM_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] RPM_MIN  = -RPM_MAX;

    if (WINDOW_CYCLES < 2 || FILT_LEN < 1) begin : g_param_check
        $error("quad_enc_rpm: WINDOW_CYCLES must be >= 2 and FILT_LEN >= 1");
    end

    logic [1:0] sync1_q, sync2_q, prev_q, cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= {enc_a, enc_b};
            sync2_q <= sync1_q;
        end
    end

`ifdef QENC_FILTER_EN
    localparam int unsigned FILT_W = $clog2(FILT_LEN + 1);

    // A channel changes only after FILT_LEN consecutive samples disagree with the held value.
    for (genvar i = 0; i < 2; i++) begin : g_filt
        logic [FILT_W-1:0] cnt_q;
        logic              val_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
                val_q <= 1'b0;
            end else if (sync2_q[i] == val_q) begin
                cnt_q <= '0;
            end else if (cnt_q == FILT_W'(FILT_LEN - 1)) begin
                cnt_q <= '0;
                val_q <= sync2_q[i];
            end else begin
                cnt_q <= cnt_q + FILT_W'(1);
            end
        end

        assign cur[i] = val_q;
    end
`else
    assign cur = sync2_q;
`endif

    logic fwd, rev, bad;

    always_comb begin
        fwd = 1'b0;
        rev = 1'b0;
        bad = 1'b0;
        case ({prev_q, cur})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: fwd = 1'b1;
            4'b0010, 4'b1011, 4'b1101, 4'b0100: rev = 1'b1;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: bad = 1'b1;
            default: ;
        endcase
    end

    logic signed [POS_W-1:0] pos_q, pos_d;
    logic signed [CNT_W-1:0] edge_q, edge_d;
    logic signed [RPM_W-1:0] rpm_q, rpm_d;
    logic [WIN_W-1:0]        win_q, win_d;
    logic                    dir_q, dir_d, err_q, err_d, valid_q, valid_d;

    logic signed [PROD_W-1:0] prod;
    logic signed [EXT_W-1:0]  prod_ext, rpm_sat;

    assign prod     = PROD_W'(edge_q) * $signed(PROD_W'(RPM_SCALE));
    assign prod_ext = EXT_W'(prod);
    assign rpm_sat  = (prod_ext > RPM_MAX) ? RPM_MAX :
                      (prod_ext < RPM_MIN) ? RPM_MIN : prod_ext;

    always_comb begin
        pos_d   = pos_q;
        dir_d   = dir_q;
        err_d   = bad;
        edge_d  = edge_q;
        rpm_d   = rpm_q;
        valid_d = 1'b0;
        win_d   = win_q + WIN_W'(1);

        if (fwd) begin
            pos_d = pos_q + POS_W'(1);
            dir_d = 1'b1;
            if (edge_q != CNT_MAX) edge_d = edge_q + CNT_W'(1);
        end else if (rev) begin
            pos_d = pos_q - POS_W'(1);
            dir_d = 1'b0;
            if (edge_q != CNT_MIN) edge_d = edge_q - CNT_W'(1);
        end

        if (clr_pos) pos_d = '0;

        // The edge decoded on the terminal cycle seeds the next window.
        if (win_q == WIN_LAST) begin
            win_d   = '0;
            valid_d = 1'b1;
            rpm_d   = RPM_W'(rpm_sat);
            edge_d  = fwd ? CNT_W'(1) : (rev ? '1 : '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= 2'b00;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
            edge_q  <= '0;
            rpm_q   <= '0;
            valid_q <= 1'b0;
            win_q   <= '0;
        end else begin
            prev_q  <= cur;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
            edge_q  <= edge_d;
            rpm_q   <= rpm_d;
            valid_q <= valid_d;
            win_q   <= win_d;
        end
    end

    assign pos       = pos_q;
    assign dir       = dir_q;
    assign rpm       = rpm_q;
    assign rpm_valid = valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_quad_enc_rpm.sv
// Directed bench for quad_enc_rpm: reset, fwd/rev speed, illegal transitions, window boundary,
// saturation (second instance with a longer window so >2047 edges fit in one window).
module tb_quad_enc_rpm;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enc_a = 1'b0, enc_b = 1'b0, clr_pos = 1'b0;
    logic signed [31:0] pos;
    logic signed [15:0] rpm;
    logic dir, rpm_valid, err;

    logic sa = 1'b0, sb = 1'b0;
    logic signed [31:0] s_pos;
    logic signed [15:0] s_rpm;
    logic s_dir, s_valid, s_err;

    int checks = 0;
    int errors = 0;
    logic [1:0] ab = 2'b00;

    always #10 clk = ~clk;

    quad_enc_rpm #(
        .WINDOW_CYCLES(1000), .RPM_SCALE(3), .CNT_W(12), .RPM_W(16), .POS_W(32), .FILT_LEN(4)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .clr_pos(clr_pos),
        .pos(pos), .dir(dir), .rpm(rpm), .rpm_valid(rpm_valid), .err(err)
    );

    quad_enc_rpm #(
        .WINDOW_CYCLES(2500), .RPM_SCALE(3), .CNT_W(12), .RPM_W(16), .POS_W(32), .FILT_LEN(4)
    ) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .enc_a(sa), .enc_b(sb), .clr_pos(1'b0),
        .pos(s_pos), .dir(s_dir), .rpm(s_rpm), .rpm_valid(s_valid), .err(s_err)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] next_ab(input logic [1:0] s, input bit fwd);
        case (s)
            2'b00:   return fwd ? 2'b01 : 2'b10;
            2'b01:   return fwd ? 2'b11 : 2'b00;
            2'b11:   return fwd ? 2'b10 : 2'b01;
            default: return fwd ? 2'b00 : 2'b11;
        endcase
    endfunction

    // Drive one edge at the current negedge, then idle for gap cycles.
    task automatic step(input bit fwd, input int gap);
        ab = next_ab(ab, fwd);
        enc_a = ab[1];
        enc_b = ab[0];
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_valid(input bit sat, input int limit, output int n, output bit hit);
        n = 0;
        hit = 1'b0;
        while (n < limit && !hit) begin
            @(negedge clk);
            n++;
            hit = sat ? s_valid : rpm_valid;
        end
    endtask

    initial begin
        int n;
        bit hit;
        int err_cnt;
        logic [1:0] sab;

        #5;
        chk("reset_pos", pos, 0);
        chk("reset_rpm", rpm, 0);
        chk("reset_valid", rpm_valid, 0);
        chk("reset_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_valid(1'b0, 1100, n, hit);
        chk("first_valid_latency", n, 1000);

        // Forward: 40 edges in one window.
        for (int i = 0; i < 40; i++) step(1'b1, 20);
        wait_valid(1'b0, 1100, n, hit);
        chk("fwd_valid_seen", hit, 1);
        chk("fwd_rpm", rpm, 120);
        chk("fwd_pos", pos, 40);
        chk("fwd_dir", dir, 1);
        @(negedge clk);
        chk("valid_one_cycle", rpm_valid, 0);

        // Reverse after position clear.
        clr_pos = 1'b1;
        @(negedge clk);
        clr_pos = 1'b0;
        chk("clr_pos", pos, 0);
        for (int i = 0; i < 40; i++) step(1'b0, 20);
        wait_valid(1'b0, 1100, n, hit);
        chk("rev_rpm", rpm, -120);
        chk("rev_pos", pos, -40);
        chk("rev_dir", dir, 0);
        wait_valid(1'b0, 1100, n, hit);
        chk("idle_rpm", rpm, 0);
        chk("idle_dir", dir, 0);

        // Illegal 00 -> 11.
        ab = 2'b11;
        enc_a = 1'b1;
        enc_b = 1'b1;
        err_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (err) err_cnt++;
        end
        chk("err_pulse_len", err_cnt, 1);
        chk("err_pos_hold", pos, -40);
        step(1'b1, 20);
        chk("after_err_pos", pos, -39);
        chk("after_err_dir", dir, 1);

        // Edge landing on the window terminal cycle belongs to the next window.
        wait_valid(1'b0, 1100, n, hit);
        for (int i = 0; i < 5; i++) step(1'b1, 20);
        repeat (897) @(negedge clk);
        step(1'b1, 0);
        wait_valid(1'b0, 10, n, hit);
        chk("term_valid_seen", hit, 1);
        chk("term_rpm_old", rpm, 15);
        for (int i = 0; i < 3; i++) step(1'b1, 20);
        wait_valid(1'b0, 1100, n, hit);
        chk("term_rpm_new", rpm, 12);
        chk("term_pos_total", pos, -30);

        // Saturation: 2100 edges in one 2500-cycle window.
        wait_valid(1'b1, 2600, n, hit);
        chk("sat_align_seen", hit, 1);
        sab = 2'b00;
        for (int i = 0; i < 2100; i++) begin
            sab = next_ab(sab, 1'b1);
            sa = sab[1];
            sb = sab[0];
            @(negedge clk);
        end
        wait_valid(1'b1, 2600, n, hit);
        chk("sat_rpm", s_rpm, 6141);
        chk("sat_pos", s_pos, 2100);

`ifdef QENC_FILTER_EN
        repeat (20) @(negedge clk);
        enc_a = ~enc_a;
        repeat (2) @(negedge clk);
        enc_a = ~enc_a;
        repeat (20) @(negedge clk);
        chk("glitch_pos", pos, -30);
`endif

        // Async reset mid-run while the encoder toggles.
        for (int i = 0; i < 6; i++) step(1'b1, 5);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_pos", pos, 0);
        chk("midrst_rpm", rpm, 0);
        chk("midrst_valid", rpm_valid, 0);
        chk("midrst_err", err, 0);
        for (int i = 0; i < 4; i++) step(1'b1, 3);
        ab = 2'b00;
        enc_a = 1'b0;
        enc_b = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_valid(1'b0, 1100, n, hit);
        chk("midrst_latency", n, 1000);
        chk("midrst_rpm_after", rpm, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
